pc_fetch_sequencer: RTL and testbench

//  Multi-cycle fetch/execute sequencer that owns the program counter for the CPU core.

---
 rtl/pc_fetch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Owns the program counter. Each instruction is fetched over a req/ack
// handshake with instruction memory, then held in EXEC while the decoder
// and ALU settle; at the end of EXEC the PC advances to the jump target,
// the taken-branch target or pc+4 (in that priority order).
// A fetch that is not acknowledged within TIMEOUT wait cycles raises a
// sticky fetch_err and parks the sequencer in HALTED, as does a retiring
// instruction that carries halt. HALTED is left only through reset.

module pc_fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              jump,
    input  logic              branch,
    input  logic              zero_flag,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [1:0]        pc_sel,
    output logic              retire,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              halted,
    output logic              fetch_err
);

    // The wait counter must be able to hold TIMEOUT-1, the last value it
    // takes before the fetch is declared lost.
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'b00,
        ST_FETCH  = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
    logic               fetch_err_q, fetch_err_d;

    logic [ADDR_W-1:0]  jump_addr;
    logic [ADDR_W-1:0]  branch_addr;
    logic [ADDR_W-1:0]  seq_addr;
    logic [ADDR_W-1:0]  next_pc;
    logic [1:0]         exec_sel;

    // Targets are forced word-aligned, so their two low bits never matter.
    logic               unused_target_low_bits;
    assign unused_target_low_bits = ^{jump_target[1:0], branch_target[1:0]};

    // Next-PC selection: jump beats a taken branch, which beats pc+4.
    // The sequential address wraps naturally at 2^ADDR_W.
    always_comb begin
        jump_addr   = {jump_target[ADDR_W-1:2], 2'b00};
        branch_addr = {branch_target[ADDR_W-1:2], 2'b00};
        seq_addr    = pc_q + ADDR_W'(4);
        next_pc     = seq_addr;
        exec_sel    = SEL_SEQ;
        if (jump) begin
            next_pc  = jump_addr;
            exec_sel = SEL_JUMP;
        end else if (branch && zero_flag) begin
            next_pc  = branch_addr;
            exec_sel = SEL_BRANCH;
        end
    end

    // Sequencer next-state and output decode. Stall holds the instruction
    // in EXEC and takes precedence over halt; a same-cycle ack beats the
    // timeout on the final wait cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tmo_d        = tmo_q;
        retire_cnt_d = retire_cnt_q;
        fetch_err_d  = fetch_err_q;
        imem_req     = 1'b0;
        retire       = 1'b0;
        pc_sel       = SEL_SEQ;
        halted       = 1'b0;

        case (state_q)
            ST_BOOT: begin
                tmo_d   = '0;
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    tmo_d   = '0;
                    state_d = ST_EXEC;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d       = '0;
                    fetch_err_d = 1'b1;
                    state_d     = ST_HALTED;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_EXEC: begin
                pc_sel = exec_sel;
                if (!stall) begin
                    pc_d         = next_pc;
                    retire       = 1'b1;
                    retire_cnt_d = retire_cnt_q + CNT_W'(1);
                    state_d      = halt ? ST_HALTED : ST_FETCH;
                end
            end

            ST_HALTED: begin
                halted = 1'b1;
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State register; reset aborts any fetch or execution in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            tmo_q        <= '0;
            retire_cnt_q <= '0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tmo_q        <= tmo_d;
            retire_cnt_q <= retire_cnt_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    // The fetch address is the PC itself; it is only meaningful while
    // imem_req is high.
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign retire_cnt = retire_cnt_q;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer
// Directed bench for the fetch sequencer. The stimulus process plays
// instructions through the fetch handshake and EXEC, pushing the expected
// fetch address and retirement record into queues; an independent monitor
// pops and compares whenever the DUT completes a fetch or retires.
// The retire counter is built narrow so its wrap is reached quickly.

module tb_pc_fetch_sequencer;

    localparam int TB_CNT_W = 3;

    typedef struct {
        logic [31:0]         pc;
        logic [1:0]          sel;
        logic [31:0]         nextPc;
        logic [TB_CNT_W-1:0] cnt;
    } retireExp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                imem_req;
    logic [31:0]         imem_addr;
    logic                imem_ack = 1'b0;
    logic                jump = 1'b0;
    logic                branch = 1'b0;
    logic                zero_flag = 1'b0;
    logic [31:0]         jump_target = '0;
    logic [31:0]         branch_target = '0;
    logic                stall = 1'b0;
    logic                halt = 1'b0;
    logic [31:0]         pc;
    logic [1:0]          pc_sel;
    logic                retire;
    logic [TB_CNT_W-1:0] retire_cnt;
    logic                halted;
    logic                fetch_err;

    int                  assertCount = 0;
    int                  failCount = 0;
    logic [TB_CNT_W-1:0] cntModel = '0;
    logic [31:0]         fetchQ[$];
    retireExp_t          retireQ[$];

    pc_fetch_sequencer #(
        .ADDR_W  (32),
        .RESET_PC(32'h0),
        .TIMEOUT (15),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .jump         (jump),
        .branch       (branch),
        .zero_flag    (zero_flag),
        .jump_target  (jump_target),
        .branch_target(branch_target),
        .stall        (stall),
        .halt         (halt),
        .pc           (pc),
        .pc_sel       (pc_sel),
        .retire       (retire),
        .retire_cnt   (retire_cnt),
        .halted       (halted),
        .fetch_err    (fetch_err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Single comparison point shared by stimulus and monitor.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Assert reset away from the clock edge, check the reset state, then
    // release and confirm the BOOT cycle issues no fetch.
    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        imem_ack = 1'b0;
        jump = 1'b0;
        branch = 1'b0;
        zero_flag = 1'b0;
        stall = 1'b0;
        halt = 1'b0;
        #1;
        checkOutput("reset_pc", pc, 32'h0);
        checkOutput("reset_imem_req", imem_req, 0);
        checkOutput("reset_retire", retire, 0);
        checkOutput("reset_retire_cnt", retire_cnt, 0);
        checkOutput("reset_halted", halted, 0);
        checkOutput("reset_fetch_err", fetch_err, 0);
        checkOutput("reset_pc_sel", pc_sel, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cntModel = '0;
        #1;
        checkOutput("boot_no_req", imem_req, 0);
    endtask

    // Play one instruction: wait for the fetch, ack it after ackDelay
    // cycles, drive the decoder/ALU inputs in EXEC, optionally stall, then
    // let it retire. Expected values are supplied by the caller.
    task automatic applyStimulus(input int ackDelay, input logic j, input logic b,
                                 input logic z, input logic [31:0] jt,
                                 input logic [31:0] bt, input int stallCycles,
                                 input logic h, input logic [31:0] expPc,
                                 input logic [1:0] expSel, input logic [31:0] expNext);
        int waitCycles;
        retireExp_t item;
        logic [TB_CNT_W-1:0] prevCnt;
        waitCycles = 0;
        while (!imem_req && waitCycles < 50) begin
            @(posedge clk);
            #1;
            waitCycles++;
        end
        checkOutput("fetch_request_seen", imem_req, 1);
        if (!imem_req) return;
        repeat (ackDelay) begin
            @(posedge clk);
            #1;
        end
        fetchQ.push_back(expPc);
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        prevCnt = cntModel;
        cntModel = cntModel + 1'b1;
        item.pc = expPc;
        item.sel = expSel;
        item.nextPc = expNext;
        item.cnt = cntModel;
        retireQ.push_back(item);
        jump = j;
        branch = b;
        zero_flag = z;
        jump_target = jt;
        branch_target = bt;
        halt = h;
        stall = (stallCycles > 0);
        for (int i = 0; i < stallCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_hold_pc", pc, expPc);
            checkOutput("stall_hold_cnt", retire_cnt, prevCnt);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        jump = 1'b0;
        branch = 1'b0;
        zero_flag = 1'b0;
        halt = 1'b0;
    endtask

    // Monitor: compare each completed fetch and each retirement against
    // the queues, and check the PC/counter one cycle after a retirement.
    initial begin : monitor
        retireExp_t cur;
        bit pending;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pending = 1'b0;
                continue;
            end
            if (pending) begin
                checkOutput("next_pc", pc, cur.nextPc);
                checkOutput("retire_cnt", retire_cnt, cur.cnt);
                pending = 1'b0;
            end
            if (imem_req && imem_ack) begin
                if (fetchQ.size() == 0) checkOutput("unexpected_fetch", imem_ack, 0);
                else checkOutput("imem_addr", imem_addr, fetchQ.pop_front());
            end
            if (retire) begin
                if (retireQ.size() == 0) begin
                    checkOutput("unexpected_retire", retire, 0);
                end else begin
                    cur = retireQ.pop_front();
                    checkOutput("retire_pc", pc, cur.pc);
                    checkOutput("pc_sel", pc_sel, cur.sel);
                    pending = 1'b1;
                end
            end
        end
    end

    // Global watchdog so the bench can never hang.
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence.
    initial begin : stimulus
        int reqCount;

        // Sequential run, a stalled instruction, branches, jump priority,
        // PC wrap with halt and retire counter wrap (3-bit counter).
        doReset();
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 2'b00, 32'h4);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h4, 2'b00, 32'h8);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 5, 0, 32'h8, 2'b00, 32'hC);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'hC, 2'b00, 32'h10);
        checkOutput("retire_cnt_after_4", retire_cnt, 4);
        applyStimulus(1, 0, 1, 0, 32'h0, 32'h40, 0, 0, 32'h10, 2'b00, 32'h14);
        applyStimulus(1, 0, 1, 1, 32'h0, 32'h43, 0, 0, 32'h14, 2'b01, 32'h40);
        applyStimulus(0, 1, 1, 1, 32'h103, 32'h200, 0, 0, 32'h40, 2'b10, 32'h100);
        applyStimulus(0, 1, 0, 0, 32'hFFFFFFFC, 32'h0, 0, 0, 32'h100, 2'b10, 32'hFFFFFFFC);
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 1, 32'hFFFFFFFC, 2'b00, 32'h0);
        checkOutput("retire_cnt_wrapped", retire_cnt, 1);
        checkOutput("halt_halted", halted, 1);
        checkOutput("halt_no_err", fetch_err, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput("halted_no_req", imem_req, 0);
            checkOutput("halted_pc_frozen", pc, 32'h0);
        end

        // Fetch timeout: with no ack the request is held for 15 cycles.
        doReset();
        reqCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (imem_req) reqCount++;
            if (halted) break;
        end
        checkOutput("timeout_req_cycles", reqCount, 15);
        checkOutput("timeout_halted", halted, 1);
        checkOutput("timeout_fetch_err", fetch_err, 1);
        checkOutput("timeout_pc", pc, 32'h0);
        checkOutput("timeout_no_req", imem_req, 0);
        @(posedge clk);
        #1;
        checkOutput("fetch_err_sticky", fetch_err, 1);

        // Ack on the last permitted wait cycle wins; halt with jump.
        doReset();
        applyStimulus(14, 1, 0, 0, 32'h123, 32'h0, 0, 1, 32'h0, 2'b10, 32'h120);
        checkOutput("late_ack_no_err", fetch_err, 0);
        checkOutput("jump_halt_halted", halted, 1);
        checkOutput("jump_halt_pc", pc, 32'h120);

        // Reset asserted mid-fetch at pc=0x20 aborts immediately.
        doReset();
        applyStimulus(1, 1, 0, 0, 32'h20, 32'h0, 0, 0, 32'h0, 2'b10, 32'h20);
        checkOutput("midfetch_req", imem_req, 1);
        checkOutput("midfetch_addr", imem_addr, 32'h20);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_pc", pc, 32'h0);
        checkOutput("abort_req", imem_req, 0);
        checkOutput("abort_cnt", retire_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cntModel = '0;
        applyStimulus(1, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 2'b00, 32'h4);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("fetch_queue_drained", fetchQ.size(), 0);
        checkOutput("retire_queue_drained", retireQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
